inference_sequencer: RTL and testbench
======================================

// Module: inference_sequencer
// PURPOSE
//   Top-level scheduler for one MNIST inference pass over the 10-class dense layer.
//   On start, and only once the image buffer is loaded, it runs these phases in order:
//     clear accumulators -> load biases (one-hot walk) -> stream 784 pixel reads
//     -> drain the memory pipeline -> run argmax over the class scores.
//   It then reports the winning digit with a done pulse. It sits between the
//   image loader/UART front end and the pixel ROM + neuron accumulator array.
// PARAMETERS
//   N_PIXELS   784  pixels per image; pixel_addr counts 0..N_PIXELS-1
//   N_CLASSES  10   output neurons/classes
//   MEM_LAT    2    pixel/weight memory read latency in cycles (>=1)
//   ACC_W      24   signed accumulator/score width
// PORTS
//   clk          in   1          clock, rising edge
//   rst          in   1          reset, asynchronous, active-high
//   start        in   1          request an inference; sampled only in IDLE
//   img_ready    in   1          image buffer full; start is ignored while low
//   hold         in   1          datapath stall; honoured in PIXEL and DRAIN only
//   pixel_addr   out  10         pixel/weight memory read address
//   pixel_valid  out  1          memory data for address issued MEM_LAT advances ago is valid
//   acc_clear    out  1          one-cycle clear of all accumulators
//   bias_sel     out  N_CLASSES  one-hot bias load strobe; bit k loads bias of class k
//   score_sel    out  4          class index being read for argmax
//   score_in     in   ACC_W      signed score of class score_sel (combinational read)
//   busy         out  1          high from the cycle after start is accepted until done
//   done         out  1          one-cycle pulse; digit is valid from this cycle
//   digit        out  4          winning class; holds until the next start is accepted
// BEHAVIOUR
//   Reset values: all outputs 0; state IDLE.
//   rst asserted mid-pass aborts to IDLE and zeroes all outputs, including digit.
//   States:
//     IDLE   -> CLEAR on start&&img_ready. start while busy or with !img_ready: ignored.
//     CLEAR  1 cycle; acc_clear=1; pixel_addr=0.
//     BIAS   N_CLASSES cycles; bias_sel = 1<<k for k=0..N_CLASSES-1.
//            At most one bit is set; bias_sel=0 outside BIAS.
//     PIXEL  Issues addr 0..N_PIXELS-1, one per unstalled cycle.
//            A MEM_LAT-deep valid shift register is fed 1 on each issue.
//            hold=1 freezes pixel_addr and the shift register and forces pixel_valid=0.
//            pixel_valid = shift_reg[MEM_LAT-1] && !hold.
//            After addr N_PIXELS-1 is issued unstalled -> DRAIN.
//            pixel_addr stays at N_PIXELS-1; never wraps.
//     DRAIN  MEM_LAT unstalled cycles, shifting 0s in so the last MEM_LAT valids emerge.
//            hold freezes the count. -> ARGMAX.
//     ARGMAX N_CLASSES cycles; score_sel=k for k=0..N_CLASSES-1.
//            k=0 loads best=score_in and idx=0.
//            k>0 updates only when score_in > best (signed, strict).
//            Ties therefore resolve to the lowest index.
//     DONE   1 cycle: done=1, digit<=idx, busy=0. -> IDLE.
//            start is sampled again from the next cycle.
//   Exactly N_PIXELS pixel_valid pulses occur per pass.
//   With hold never asserted, latency is fixed:
//     done rises 1+N_CLASSES+N_PIXELS+MEM_LAT+N_CLASSES edges after the sampling edge.
//     Default value: 807 edges.
//   Counters are sized by $clog2 of the bound.
//   No arithmetic overflow: comparisons only, with score_in treated as signed.
// STRUCTURE
//   mnist_pkg: N_PIXELS, N_CLASSES, ACC_W, PIX_AW=$clog2(N_PIXELS),
//     CLS_AW=$clog2(N_CLASSES), and the state encoding
//     (IDLE, CLEAR, BIAS, PIXEL, DRAIN, ARGMAX, DONE).
//   Sub-module argmax_unit holds best/idx, the signed compare and the first-element load.
//   The sequencer FSM, counters and valid shift register stay in this module.
// TESTING
//   1. Reset, then start=1 with img_ready=1 and hold=0.
//      -> acc_clear high at edge1.
//      -> bias_sel walks 0x001..0x200.
//      -> 784 pixel_valid pulses, the first 2 cycles after addr 0.
//      -> done at edge 807.
//   2. start=1 with img_ready=0 for 20 cycles -> stays IDLE, busy=0, no outputs change.
//      Then raise img_ready -> pass begins.
//   3. hold=1 for 5 cycles at addr 100, and for 3 cycles during DRAIN.
//      -> pixel_addr frozen and pixel_valid=0 while held.
//      -> still exactly 784 valids in total; done at edge 815.
//   4. Scores {5,-3,9,9,0,...}.
//      -> digit=2 (lowest index wins the tie).
//      All scores -100 -> digit=0.
//      Score 7 is 0x7FFFFF and the others are negative -> digit=7 (signed compare).
//   5. Assert rst at addr 400 -> all outputs 0 immediately and state IDLE.
//      A new start then completes a normal 807-edge pass.
//   6. Pulse start during ARGMAX -> ignored; a single done pulse results and digit is unchanged.

Source files
------------

// File: rtl/mnist_pkg.sv
// Shared constants and state encoding for the MNIST inference sequencer slice.
package mnist_pkg;

  localparam int N_PIXELS  = 784;
  localparam int N_CLASSES = 10;
  localparam int ACC_W     = 24;
  localparam int PIX_AW    = $clog2(N_PIXELS);
  localparam int CLS_AW    = $clog2(N_CLASSES);

  // Phases of one inference pass, in execution order.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    BIAS   = 3'd2,
    PIXEL  = 3'd3,
    DRAIN  = 3'd4,
    ARGMAX = 3'd5,
    DONE   = 3'd6
  } seq_state_t;

endpackage

// File: rtl/inference_sequencer_argmax.sv
// Running argmax over class scores presented one per cycle.
// The first element loads unconditionally; later elements replace the
// current best only when strictly greater (signed), so ties keep the
// lowest index. idx_next exposes the decision including the current
// element so the caller can capture the final winner on the last step.
module argmax_unit
  import mnist_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [CLS_AW-1:0] sel,
  input  logic [ACC_W-1:0]  score_in,
  output logic [CLS_AW-1:0] idx_next
);

  logic signed [ACC_W-1:0] best_reg;
  logic signed [ACC_W-1:0] best_next;
  logic [CLS_AW-1:0]       idx_reg;
  logic                    take;

  // Decide whether the current score becomes the new best.
  always_comb begin
    take      = load || ($signed(score_in) > best_reg);
    best_next = take ? $signed(score_in) : best_reg;
    idx_next  = idx_reg;
    if (take) begin
      idx_next = load ? '0 : sel;
    end
  end

  // Hold the best score and its index while a scan is running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_reg <= '0;
      idx_reg  <= '0;
    end else if (en) begin
      best_reg <= best_next;
      idx_reg  <= idx_next;
    end
  end

endmodule

// File: rtl/inference_sequencer.sv
// Top-level scheduler for one inference pass of the 10-class dense layer:
// clear accumulators, walk the bias strobes, stream every pixel address,
// drain the memory pipeline, then pick the winning class.
module inference_sequencer
  import mnist_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 img_ready,
  input  logic                 hold,
  output logic [PIX_AW-1:0]    pixel_addr,
  output logic                 pixel_valid,
  output logic                 acc_clear,
  output logic [N_CLASSES-1:0] bias_sel,
  output logic [CLS_AW-1:0]    score_sel,
  input  logic [ACC_W-1:0]     score_in,
  output logic                 busy,
  output logic                 done,
  output logic [CLS_AW-1:0]    digit
);

  // Drain counter must be at least one bit wide even for a single-cycle memory.
  localparam int DRN_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [PIX_AW-1:0] LAST_PIX = PIX_AW'(N_PIXELS - 1);
  localparam logic [CLS_AW-1:0] LAST_CLS = CLS_AW'(N_CLASSES - 1);
  localparam logic [DRN_W-1:0]  LAST_DRN = DRN_W'(MEM_LAT - 1);

  seq_state_t          state_reg;
  seq_state_t          state_next;
  logic [PIX_AW-1:0]   pix_cnt_reg;
  logic [CLS_AW-1:0]   cls_cnt_reg;
  logic [DRN_W-1:0]    drn_cnt_reg;
  logic [MEM_LAT-1:0]  valid_sr_reg;
  logic [CLS_AW-1:0]   digit_reg;

  logic                pix_last;
  logic                cls_last;
  logic                drn_last;
  logic                mem_phase;
  logic                am_en;
  logic                am_load;
  logic [CLS_AW-1:0]   am_idx_next;

  assign pix_last  = (pix_cnt_reg == LAST_PIX);
  assign cls_last  = (cls_cnt_reg == LAST_CLS);
  assign drn_last  = (drn_cnt_reg == LAST_DRN);
  // hold only matters while the memory pipeline is in flight.
  assign mem_phase = (state_reg == PIXEL) || (state_reg == DRAIN);

  // State register; reset aborts any pass in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and per-phase control strobes.
  always_comb begin
    state_next = state_reg;
    acc_clear  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    am_en      = 1'b0;
    am_load    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && img_ready) begin
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        busy       = 1'b1;
        acc_clear  = 1'b1;
        state_next = BIAS;
      end
      BIAS: begin
        busy = 1'b1;
        if (cls_last) begin
          state_next = PIXEL;
        end
      end
      PIXEL: begin
        busy = 1'b1;
        if (!hold && pix_last) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (!hold && drn_last) begin
          state_next = ARGMAX;
        end
      end
      ARGMAX: begin
        busy    = 1'b1;
        am_en   = 1'b1;
        am_load = (cls_cnt_reg == '0);
        if (cls_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Phase counters and the read-valid pipeline; all frozen by hold in PIXEL/DRAIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt_reg  <= '0;
      cls_cnt_reg  <= '0;
      drn_cnt_reg  <= '0;
      valid_sr_reg <= '0;
    end else begin
      case (state_reg)
        CLEAR: begin
          pix_cnt_reg  <= '0;
          cls_cnt_reg  <= '0;
          drn_cnt_reg  <= '0;
          valid_sr_reg <= '0;
        end
        BIAS, ARGMAX: begin
          cls_cnt_reg <= cls_last ? '0 : cls_cnt_reg + 1'b1;
        end
        PIXEL: begin
          if (!hold) begin
            // Each issued address will return data MEM_LAT advances later.
            valid_sr_reg <= (valid_sr_reg << 1) | MEM_LAT'(1);
            // Stays on the last address instead of wrapping.
            if (!pix_last) begin
              pix_cnt_reg <= pix_cnt_reg + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (!hold) begin
            valid_sr_reg <= valid_sr_reg << 1;
            drn_cnt_reg  <= drn_last ? '0 : drn_cnt_reg + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Capture the winner on the last argmax step so digit is valid with done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_reg <= '0;
    end else if (state_reg == ARGMAX && cls_last) begin
      digit_reg <= am_idx_next;
    end
  end

  argmax_unit u_argmax (
    .clk      (clk),
    .rst      (rst),
    .en       (am_en),
    .load     (am_load),
    .sel      (cls_cnt_reg),
    .score_in (score_in),
    .idx_next (am_idx_next)
  );

  // One-hot bias strobe decoded from the class counter.
  generate
    for (genvar gi = 0; gi < N_CLASSES; gi++) begin : g_bias
      assign bias_sel[gi] = (state_reg == BIAS) && (cls_cnt_reg == CLS_AW'(gi));
    end
  endgenerate

  assign pixel_addr  = mem_phase ? pix_cnt_reg : '0;
  assign pixel_valid = mem_phase && valid_sr_reg[MEM_LAT-1] && !hold;
  assign score_sel   = (state_reg == ARGMAX) ? cls_cnt_reg : '0;
  assign digit       = digit_reg;

endmodule

// File: tb/tb_inference_sequencer.sv
// Bench for inference_sequencer: a progress-count model predicts every output
// each cycle; directed passes exercise holds, ties, signed scores, reset abort
// and a stray start during argmax.
module tb_inference_sequencer;

  localparam int NP     = 784;
  localparam int NC     = 10;
  localparam int LAT    = 2;
  // Progress index (advancing cycles since acceptance) at which each phase begins.
  localparam int P_BIAS = 1;
  localparam int P_PIX  = P_BIAS + NC;
  localparam int P_DRN  = P_PIX + NP;
  localparam int P_ARG  = P_DRN + LAT;
  localparam int P_DONE = P_ARG + NC;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        img_ready;
  logic        hold;
  logic [9:0]  pixel_addr;
  logic        pixel_valid;
  logic        acc_clear;
  logic [9:0]  bias_sel;
  logic [3:0]  score_sel;
  logic [23:0] score_in;
  logic        busy;
  logic        done;
  logic [3:0]  digit;

  logic signed [23:0] scores [NC];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int done_cnt = 0;
  int last_lat = 0;
  int acc_edge = 0;

  bit m_active = 1'b0;
  int m_p = 0;
  int m_digit = 0;

  always #5 clk = ~clk;

  assign score_in = (score_sel < 4'd10) ? scores[score_sel] : 24'h0;

  inference_sequencer #(.MEM_LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .img_ready  (img_ready),
    .hold       (hold),
    .pixel_addr (pixel_addr),
    .pixel_valid(pixel_valid),
    .acc_clear  (acc_clear),
    .bias_sel   (bias_sel),
    .score_sel  (score_sel),
    .score_in   (score_in),
    .busy       (busy),
    .done       (done),
    .digit      (digit)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference argmax straight from the rule: first max, signed, strict.
  function automatic int ref_argmax();
    int best_i = 0;
    for (int k = 1; k < NC; k++) begin
      if (scores[k] > scores[best_i]) best_i = k;
    end
    return best_i;
  endfunction

  function automatic int f_bias(input bit act, input int p);
    if (act && p >= P_BIAS && p < P_PIX) return 1 << (p - P_BIAS);
    return 0;
  endfunction

  function automatic int f_addr(input bit act, input int p);
    if (act && p >= P_PIX && p < P_DRN) return p - P_PIX;
    if (act && p >= P_DRN && p < P_ARG) return NP - 1;
    return 0;
  endfunction

  function automatic int f_valid(input bit act, input int p, input logic h);
    return (act && !h && p >= P_PIX + LAT && p < P_ARG) ? 1 : 0;
  endfunction

  function automatic int f_sel(input bit act, input int p);
    if (act && p >= P_ARG && p < P_DONE) return p - P_ARG;
    return 0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Model: a pass is just a progress count that advances unless held in the memory phases.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_p      <= 0;
      m_digit  <= 0;
    end else if (!m_active) begin
      if (start && img_ready) begin
        m_active <= 1'b1;
        m_p      <= 0;
        acc_edge <= cyc + 1;
      end
    end else if (m_p == P_DONE) begin
      m_active <= 1'b0;
    end else if (!(hold && m_p >= P_PIX && m_p < P_ARG)) begin
      m_p <= m_p + 1;
      if (m_p == P_DONE - 1) m_digit <= ref_argmax();
    end
  end

  // Compare every output against the model once per cycle.
  always @(negedge clk) begin
    chk("acc_clear",   32'(acc_clear),   32'(m_active && m_p == 0));
    chk("bias_sel",    32'(bias_sel),    32'(f_bias(m_active, m_p)));
    chk("pixel_addr",  32'(pixel_addr),  32'(f_addr(m_active, m_p)));
    chk("pixel_valid", 32'(pixel_valid), 32'(f_valid(m_active, m_p, hold)));
    chk("score_sel",   32'(score_sel),   32'(f_sel(m_active, m_p)));
    chk("busy",        32'(busy),        32'(m_active && m_p != P_DONE));
    chk("done",        32'(done),        32'(m_active && m_p == P_DONE));
    chk("digit",       32'(digit),       32'(m_digit));
    if (pixel_valid) valid_cnt <= valid_cnt + 1;
    if (done) begin
      done_cnt <= done_cnt + 1;
      last_lat <= cyc - acc_edge;
    end
  end

  task automatic set_all(input int v);
    for (int k = 0; k < NC; k++) scores[k] = 24'(v);
  endtask

  // One pass: accept, optional holds / reset / stray start, then wait for done.
  task automatic do_pass(input string nm, input int exp_lat, input int exp_digit,
                         input int hold_addr, input int hold_len, input int drain_len,
                         input int rst_addr, input bit poke_argmax);
    int v0 = valid_cnt;
    int d0 = done_cnt;
    int h1 = hold_len;
    int h2 = drain_len;
    bit fin = 1'b0;
    bit aborted = 1'b0;
    img_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, ".accepted"}, 32'(busy), 32'd1);
    for (int c = 0; c < 2000 && !fin; c++) begin
      hold = 1'b0;
      start = 1'b0;
      if (rst_addr >= 0 && m_active && m_p == P_PIX + rst_addr) begin
        rst = 1'b1;
        #2;
        chk({nm, ".rst_busy"}, 32'(busy), 32'd0);
        chk({nm, ".rst_addr"}, 32'(pixel_addr), 32'd0);
        chk({nm, ".rst_digit"}, 32'(digit), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        aborted = 1'b1;
        fin = 1'b1;
      end else begin
        if (h1 > 0 && m_active && m_p == P_PIX + hold_addr) begin
          hold = 1'b1;
          h1--;
        end else if (h2 > 0 && m_active && m_p == P_DRN) begin
          hold = 1'b1;
          h2--;
        end
        if (poke_argmax && m_active && m_p == P_ARG + 3) start = 1'b1;
        @(posedge clk); #1;
        if (done_cnt != d0) fin = 1'b1;
      end
    end
    hold = 1'b0;
    start = 1'b0;
    if (aborted) begin
      chk({nm, ".no_done"}, 32'(done_cnt - d0), 32'd0);
    end else begin
      chk({nm, ".finished"}, 32'(fin), 32'd1);
      chk({nm, ".latency"}, 32'(last_lat), 32'(exp_lat));
      chk({nm, ".valids"}, 32'(valid_cnt - v0), 32'd784);
      chk({nm, ".digit"}, 32'(digit), 32'(exp_digit));
      repeat (4) @(posedge clk);
      #1;
      chk({nm, ".done_pulses"}, 32'(done_cnt - d0), 32'd1);
      chk({nm, ".idle"}, 32'(busy), 32'd0);
    end
    $display("pass %s: latency=%0d valids=%0d digit=%0d", nm, last_lat, valid_cnt - v0, digit);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    img_ready = 1'b0;
    hold = 1'b0;
    set_all(0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.digit", 32'(digit), 32'd0);
    chk("reset.bias_sel", 32'(bias_sel), 32'd0);

    // Tie between classes 2 and 3: lowest index wins.
    set_all(0);
    scores[0] = 24'sd5; scores[1] = -24'sd3; scores[2] = 24'sd9; scores[3] = 24'sd9;
    do_pass("basic", 807, 2, 0, 0, 0, -1, 1'b0);

    // start held without img_ready is ignored.
    img_ready = 1'b0;
    start = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("noimg.busy", 32'(busy), 32'd0);
    chk("noimg.digit", 32'(digit), 32'd2);
    set_all(-100);
    do_pass("allneg", 807, 0, 0, 0, 0, -1, 1'b0);

    // Stalls at address 100 and in drain; most-positive score among negatives.
    set_all(-5);
    scores[0] = 24'sh800000;
    scores[7] = 24'sh7FFFFF;
    do_pass("hold", 815, 7, 100, 5, 3, -1, 1'b0);

    // Abort mid-pixel stream, then a clean pass.
    set_all(10);
    scores[9] = 24'sd50;
    do_pass("abort", 0, 0, 0, 0, 0, 400, 1'b0);
    do_pass("after_rst", 807, 9, 0, 0, 0, -1, 1'b0);

    // Stray start during argmax.
    do_pass("poke", 807, 9, 0, 0, 0, -1, 1'b1);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
